// File: rtl/cm_unpack_decode_pkg.sv
// -----------------------------------------------------------------------------
// cm_unpack_decode_pkg
// Shared Saber constants for the encryption pack and decryption unpack stages:
// modulus widths, the two rounding constants, polynomial size with the BRAM
// word counts that follow from it, and the unpack/decode FSM state type.
// No ports.
// -----------------------------------------------------------------------------
package cm_unpack_decode_pkg;

   localparam int EQ = 13;
   localparam int EP = 10;
   localparam int ET = 4;

   // h1 is used by the encryption pack stage, h2 by the decryption decode.
   localparam logic [9:0] SABER_H1 = 10'(1 << (EQ - EP - 1));
   localparam logic [9:0] SABER_H2 = 10'((1 << (EP - 2)) - (1 << (EP - ET - 1)) + (1 << (EQ - EP - 1)));

   localparam int SABER_N   = 256;
   localparam int V_WORDS   = SABER_N / 4;   // four 10-bit coeffs per 64-bit word
   localparam int CM_WORDS  = SABER_N / 16;  // sixteen 4-bit coeffs per word
   localparam int MSG_WORDS = SABER_N / 64;  // one bit per coefficient

   typedef enum logic [3:0] {
      S_IDLE,
      S_CM_REQ,
      S_CM_LOAD,
      S_V0,
      S_V1,
      S_V2,
      S_V3,
      S_V4,
      S_WR,
      S_DONE
   } state_e;

endpackage

// File: rtl/cm_unpack_decode_if.sv
// -----------------------------------------------------------------------------
// cm_unpack_decode_if
// Control and shared-BRAM bus of the unpack/decode stage.
//   start          : run request pulse
//   read_base_sel  : 1 = cm region, 0 = v region
//   read_address   : word address in the selected region
//   read_data      : BRAM data, one cycle after read_address
//   write_address  : message word address 0..3
//   write_data     : packed message word
//   write_en       : one-cycle write strobe per word
//   done           : run finished
// master = decode stage, slave = BRAM/controller side.
// -----------------------------------------------------------------------------
interface cm_unpack_decode_if;
   logic        start;
   logic        read_base_sel;
   logic [8:0]  read_address;
   logic [63:0] read_data;
   logic [8:0]  write_address;
   logic [63:0] write_data;
   logic        write_en;
   logic        done;

   modport master (
      input  start, read_data,
      output read_base_sel, read_address, write_address, write_data, write_en, done
   );

   modport slave (
      output start, read_data,
      input  read_base_sel, read_address, write_address, write_data, write_en, done
   );
endinterface

// File: rtl/cm_unpack_decode_lane.sv
// -----------------------------------------------------------------------------
// cm_unpack_decode_lane
// Combinational 4-lane message decoder. For each lane L:
//   d = v_L + H2 - (cm_L << 6)  (10-bit wrap-around),  m_L = d[9]
// Ports:
//   v_lanes_i  : {v3, v2, v1, v0}, 10 bits each
//   cm_bits_i  : {cm3, cm2, cm1, cm0}, 4 bits each
//   m_o        : {m3, m2, m1, m0}
// -----------------------------------------------------------------------------
module cm_unpack_decode_lane
   import cm_unpack_decode_pkg::*;
#(
   parameter logic [9:0] H2 = SABER_H2
) (
   input  logic [39:0] v_lanes_i,
   input  logic [15:0] cm_bits_i,
   output logic [3:0]  m_o
);

   logic [9:0] d;

   always_comb begin
      m_o = '0;
      d   = '0;
      for (int l = 0; l < 4; l++) begin
         d      = v_lanes_i[10*l +: 10] + H2 - {cm_bits_i[4*l +: 4], 6'd0};
         m_o[l] = d[9];
      end
   end

endmodule

// File: rtl/cm_unpack_decode.sv
// -----------------------------------------------------------------------------
// cm_unpack_decode
// Reads packed 4-bit cm and 10-bit v polynomials from the shared BRAM, decodes
// one message bit per coefficient and writes the 256 bits back as four 64-bit
// words. One cm word covers four v words (a "group" of 7 cycles); every fourth
// group ends with a write cycle.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : cm_unpack_decode_if.master (start/done, BRAM read and write)
// -----------------------------------------------------------------------------
module cm_unpack_decode
   import cm_unpack_decode_pkg::*;
#(
   parameter logic [9:0] H2      = SABER_H2,
   parameter int         N_COEFF = SABER_N
) (
   input  logic                  clk,
   input  logic                  rst,
   cm_unpack_decode_if.master    bus
);

   localparam logic [6:0] V_LAST = 7'(N_COEFF / 4);

   state_e      state_q;
   logic [6:0]  v_addr_q;
   logic [8:0]  wr_addr_q;
   logic [8:0]  rd_addr_q;
   logic        rd_sel_q;
   logic        wr_en_q;
   logic        done_q;
   logic [63:0] cm_q, cm_d;
   logic [63:0] msg_q, msg_d;
   logic [3:0]  m_bits;

   cm_unpack_decode_lane #(.H2(H2)) u_lane (
      .v_lanes_i ({bus.read_data[57:48], bus.read_data[41:32],
                   bus.read_data[25:16], bus.read_data[9:0]}),
      .cm_bits_i (cm_q[15:0]),
      .m_o       (m_bits)
   );

   // Next values of the buffers when a v word is consumed.
   assign cm_d  = {16'd0, cm_q[63:16]};
   assign msg_d = {m_bits, msg_q[63:4]};

   assign bus.read_base_sel = rd_sel_q;
   assign bus.read_address  = rd_addr_q;
   assign bus.write_address = wr_addr_q;
   assign bus.write_data    = msg_q;
   assign bus.write_en      = wr_en_q;
   assign bus.done          = done_q;

   // Outputs are registered for the state being entered, so read_address is
   // on the bus during the issuing state and the data arrives in the next one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         v_addr_q  <= '0;
         wr_addr_q <= '0;
         rd_addr_q <= '0;
         rd_sel_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
         cm_q      <= '0;
         msg_q     <= '0;
      end else begin
         rd_sel_q <= 1'b0;
         wr_en_q  <= 1'b0;
         case (state_q)
            S_IDLE, S_DONE: begin
               done_q <= (state_q == S_DONE);
               if (bus.start) begin
                  state_q   <= S_CM_REQ;
                  v_addr_q  <= '0;
                  wr_addr_q <= '0;
                  cm_q      <= '0;
                  msg_q     <= '0;
                  rd_sel_q  <= 1'b1;
                  rd_addr_q <= '0;
                  done_q    <= 1'b0;
               end
            end
            S_CM_REQ: state_q <= S_CM_LOAD;
            S_CM_LOAD: begin
               cm_q      <= bus.read_data;
               rd_addr_q <= {2'b00, v_addr_q};
               v_addr_q  <= v_addr_q + 7'd1;
               state_q   <= S_V0;
            end
            S_V0: begin
               rd_addr_q <= {2'b00, v_addr_q};
               v_addr_q  <= v_addr_q + 7'd1;
               state_q   <= S_V1;
            end
            S_V1, S_V2: begin
               rd_addr_q <= {2'b00, v_addr_q};
               v_addr_q  <= v_addr_q + 7'd1;
               msg_q     <= msg_d;
               cm_q      <= cm_d;
               state_q   <= (state_q == S_V1) ? S_V2 : S_V3;
            end
            S_V3: begin
               msg_q   <= msg_d;
               cm_q    <= cm_d;
               state_q <= S_V4;
            end
            S_V4: begin
               msg_q <= msg_d;
               cm_q  <= cm_d;
               // Sixteen v words fill one message word.
               if (v_addr_q[3:0] == 4'd0) begin
                  state_q <= S_WR;
                  wr_en_q <= 1'b1;
               end else begin
                  state_q   <= S_CM_REQ;
                  rd_sel_q  <= 1'b1;
                  rd_addr_q <= {5'd0, v_addr_q[5:2]};
               end
            end
            S_WR: begin
               wr_addr_q <= wr_addr_q + 9'd1;
               if (v_addr_q == V_LAST) begin
                  state_q <= S_DONE;
               end else begin
                  state_q   <= S_CM_REQ;
                  rd_sel_q  <= 1'b1;
                  rd_addr_q <= {5'd0, v_addr_q[5:2]};
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cm_unpack_decode.sv
// -----------------------------------------------------------------------------
// tb_cm_unpack_decode
// Scoreboard bench: each run pushes the expected message words into a queue,
// a monitor pops and compares on every write strobe. Includes a BRAM model.
// -----------------------------------------------------------------------------
module tb_cm_unpack_decode;
   import cm_unpack_decode_pkg::*;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   cm_unpack_decode_if bus_if ();

   cm_unpack_decode dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   logic [63:0] v_mem  [64];
   logic [63:0] cm_mem [16];

   always @(posedge clk)
      bus_if.read_data <= bus_if.read_base_sel ? cm_mem[bus_if.read_address[3:0]]
                                               : v_mem[bus_if.read_address[5:0]];

   // Reference polynomials and message.
   logic [9:0]   vc [256];
   logic [3:0]   cc [256];
   logic [255:0] msg;

   int total = 0;
   int bad   = 0;
   int we_cnt = 0;
   int rbs_cnt = 0;

   typedef struct {
      logic [8:0]  addr;
      logic [63:0] data;
   } exp_t;
   exp_t sbq[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // Monitor: compare every written word against the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (bus_if.read_base_sel === 1'b1) rbs_cnt++;
      if (bus_if.write_en === 1'b1) begin
         we_cnt++;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0d want none", bus_if.write_address);
         end else begin
            e = sbq.pop_front();
            chk("write_address", 64'(bus_if.write_address), 64'(e.addr));
            chk("write_data", bus_if.write_data, e.data);
         end
      end
   end

   task automatic clear_model();
      for (int i = 0; i < 256; i++) begin
         vc[i] = '0;
         cc[i] = '0;
      end
      msg = '0;
   endtask

   task automatic build_mem();
      for (int w = 0; w < 64; w++) begin
         v_mem[w] = '0;
         for (int l = 0; l < 4; l++) v_mem[w][16*l +: 10] = vc[4*w + l];
      end
      for (int k = 0; k < 16; k++) begin
         cm_mem[k] = '0;
         for (int n = 0; n < 16; n++) cm_mem[k][4*n +: 4] = cc[16*k + n];
      end
   endtask

   task automatic push_expect();
      exp_t e;
      for (int j = 0; j < 4; j++) begin
         e.addr = 9'(j);
         e.data = msg[64*j +: 64];
         sbq.push_back(e);
      end
   endtask

   // One full run: start, wait (bounded) for done, check timing and counts.
   task automatic run_and_check(input string tag, input bit stray);
      int we0, rb0, cyc;
      we0 = we_cnt;
      rb0 = rbs_cnt;
      @(negedge clk);
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      cyc = 0;
      while (bus_if.done !== 1'b1 && cyc < 200) begin
         @(posedge clk);
         #1;
         cyc++;
         bus_if.start = (stray && cyc == 30);
      end
      bus_if.start = 1'b0;
      chk({tag, " done_cycle"}, 64'(cyc), 64'd117);
      chk({tag, " write_count"}, 64'(we_cnt - we0), 64'd4);
      chk({tag, " cm_reads"}, 64'(rbs_cnt - rb0), 64'd16);
      chk({tag, " sb_empty"}, 64'(sbq.size()), 64'd0);
      sbq.delete();
      repeat (3) @(posedge clk);
      #1;
      chk({tag, " done_held"}, 64'(bus_if.done), 64'd1);
      chk({tag, " waddr_hold"}, 64'(bus_if.write_address), 64'd4);
   endtask

   task automatic single(input string tag, input int idx, input logic [9:0] v,
                         input logic [3:0] c, input logic m);
      clear_model();
      vc[idx]  = v;
      cc[idx]  = c;
      msg[idx] = m;
      build_mem();
      push_expect();
      run_and_check(tag, 1'b0);
   endtask

   initial begin
      logic [9:0] x;
      exp_t e;
      rst = 1'b1;
      bus_if.start = 1'b0;
      clear_model();
      build_mem();
      repeat (3) @(posedge clk);
      #1;
      chk("rst read_base_sel", 64'(bus_if.read_base_sel), 64'd0);
      chk("rst read_address", 64'(bus_if.read_address), 64'd0);
      chk("rst write_en", 64'(bus_if.write_en), 64'd0);
      chk("rst done", 64'(bus_if.done), 64'd0);
      chk("rst write_address", 64'(bus_if.write_address), 64'd0);
      chk("rst write_data", bus_if.write_data, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Single coefficients, expected bits computed by hand.
      single("c0 v0 cm0", 0, 10'd0, 4'd0, 1'b0);
      single("c0 v300", 0, 10'd300, 4'd0, 1'b1);
      single("c0 cm8 wrap", 0, 10'd0, 4'd8, 1'b1);
      single("c0 v1023 cm15", 0, 10'd1023, 4'd15, 1'b0);
      single("c0 v900 ovf", 0, 10'd900, 4'd0, 1'b0);
      single("c255 v300", 255, 10'd300, 4'd0, 1'b1);
      single("c77 cm8", 77, 10'd0, 4'd8, 1'b1);
      single("c130 v511", 130, 10'd511, 4'd0, 1'b1);

      // Stray start while busy is ignored; then start in DONE reruns the same data.
      clear_model();
      vc[5] = 10'd300; msg[5] = 1'b1;
      vc[70] = 10'd0; cc[70] = 4'd8; msg[70] = 1'b1;
      vc[200] = 10'd600; msg[200] = 1'b1;
      build_mem();
      push_expect();
      run_and_check("stray start", 1'b1);
      push_expect();
      run_and_check("rerun in done", 1'b0);

      // Reset mid-run: only word 0 is written before the abort.
      e.addr = 9'd0;
      e.data = msg[63:0];
      sbq.push_back(e);
      @(negedge clk);
      bus_if.start = 1'b1;
      @(posedge clk);
      #1 bus_if.start = 1'b0;
      repeat (50) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst write_en", 64'(bus_if.write_en), 64'd0);
      chk("midrst done", 64'(bus_if.done), 64'd0);
      chk("midrst read_base_sel", 64'(bus_if.read_base_sel), 64'd0);
      chk("midrst write_address", 64'(bus_if.write_address), 64'd0);
      chk("midrst write_data", bus_if.write_data, 64'd0);
      chk("midrst sb_empty", 64'(sbq.size()), 64'd0);
      sbq.delete();
      @(negedge clk);
      rst = 1'b0;
      push_expect();
      run_and_check("after midrst", 1'b0);

      // Round trip through the encryption pack equation.
      for (int s = 0; s < 100; s++) begin
         void'($urandom(s + 1));
         for (int i = 0; i < 256; i++) begin
            msg[i] = 1'($urandom);
            vc[i]  = 10'($urandom);
            x      = vc[i] + SABER_H1 + {msg[i], 9'd0};
            cc[i]  = x[9:6];
         end
         build_mem();
         push_expect();
         run_and_check("roundtrip", 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cm_unpack_decode.md
# cm_unpack_decode

Decryption-side neighbour of the encryption pack stage. It reads the packed 4-bit ciphertext polynomial cm and the 10-bit polynomial v from the shared BRAM. For every coefficient it computes m[i] = ((v[i] + h2 − (cm[i] << 6)) mod 1024) >> 9, packs the 256 recovered message bits into four 64-bit words, and writes them back. It sits after the inner-product multiplier in the decryption datapath and produces the message consumed by the re-encryption/hash stage.

## Interface
Parameters:
- H2, 10'd228: rounding constant (1<<8) − (1<<5) + (1<<2) for EQ=13, EP=10, ET=4.
- N_COEFF, 256: coefficients per polynomial; fixes 64 v words, 16 cm words, 4 output words.

Ports:
- clk  in  1  system clock; one clock domain.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  single-cycle pulse; sampled only in IDLE or DONE.
- read_base_sel  out  1  BRAM region select; 1 = cm region, 0 = v region.
- read_address  out  9  word address within the selected region.
- read_data  in  64  BRAM data; valid one cycle after read_address.
- write_address  out  9  message word address, 0..3.
- write_data  out  64  packed message word.
- write_en  out  1  write strobe; one cycle per word.
- done  out  1  high while in DONE.

## Operation
- Data layout:
  - v word w holds coefficients 4w..4w+3 in bits [9:0], [25:16], [41:32], [57:48].
  - cm word k holds coefficients 16k..16k+15 as nibbles, with bits [3:0] first.
  - Message word j, bit b = m[64j+b].
- Counters:
  - v_addr (7 bit, 0..64).
  - write_address (9 bit).
  - cm word index = v_addr[5:2].
- cm_buffer (64 bit):
  - Loaded from read_data in CM_LOAD.
  - Shifted right by 16 after each processed v word.
- msg_buffer (64 bit):
  - Each processed v word shifts in {m3,m2,m1,m0}, so msg_buffer <= {m3,m2,m1,m0, msg_buffer[63:4]}.
  - After 16 shifts, bit b = m[64j+b].
- Per-lane arithmetic, lane L = 0..3:
  - d = v_L + H2 − {cm_buffer[4L+3:4L], 6'd0}, computed in 10 bits with wrap-around.
  - m_L = d[9].
- FSM states:
  - IDLE: start → CM_REQ.
  - CM_REQ: read_base_sel=1, read_address={5'd0, v_addr[5:2]}. → CM_LOAD.
  - CM_LOAD: capture cm_buffer. → V0.
  - V0: issue v read at v_addr, increment v_addr. → V1.
  - V1, V2, V3: issue v read and increment v_addr; process the previous word. V1 → V2 → V3 → V4.
  - V4: process the last word, no read issued. If v_addr[3:0]==0 → WR; else → CM_REQ.
  - WR: write_en=1, then increment write_address. If v_addr==64 → DONE; else → CM_REQ.
  - DONE: done=1, all reads and writes idle. start → CM_REQ, with v_addr, write_address and buffers cleared in the same cycle.
- start in any state other than IDLE or DONE is ignored.

## Timing
- Reset values:
  - state = IDLE.
  - v_addr = 0, write_address = 0.
  - read_base_sel = 0, read_address = 0.
  - write_en = 0, done = 0.
  - write_data = 0 (buffers cleared).
- rst asserted mid-run aborts at the next edge. No write is issued in the cycle after rst.
- Each cm group takes 7 cycles; the full run is 16 groups plus 4 WR cycles = 116 busy cycles.
- With start sampled at edge t, done rises at edge t+117.
- WR cycles:
  - Occur at the end of groups 4, 8, 12 and 16.
  - write_address runs 0, 1, 2, 3; write_data is stable in the WR cycle.
- write_address holds at 4 in DONE and does not wrap.

## Structure
- Shared saber package holds EP, ET, EQ, H2, N_COEFF, and the v/cm/message word-count constants. The encryption pack stage's h1 constant moves into the same package.
- One natural sub-module, decode_lane: a combinational 4-lane decoder (v word + 16 cm bits → 4 message bits). Instantiated once; reusable by the verification model.

## Test plan
- Single coefficient values, one per case, with all else zero:
  - v0=0, cm0=0 → m[0]=0.
  - v0=300, cm0=0 → m[0]=1.
  - v0=0, cm0=8 → m[0]=1 (wrap, d=740).
  - v0=1023, cm0=15 → m[0]=0 (d=291).
  - v0=900, cm0=0 → m[0]=0 (overflow, d=104).
- Timing: start at t → exactly four write_en pulses at addresses 0..3; done at t+117 and held; read_base_sel=1 exactly 16 times.
- Round-trip: random message and v run through the encryption pack stage to produce cm; decoding returns identical 256 bits for 100 random seeds.
- Reset mid-run: rst at cycle 50 → next cycle state IDLE, write_en=0, done=0. A subsequent start produces a correct full result.
- Protocol: start pulsed during busy is ignored with no restart. start in DONE reruns and rewrites words 0..3 with identical data.
